dmem_arbiter: RTL and testbench
===============================

# dmem_arbiter

Two-requester arbiter and sequencer for the single-port 16-bit data memory. It sits between the CPU's MEM stage and the data RAM, and shares that RAM with an external host/loader port. The host port is used for program-data load, debug peek/poke and DMA. The block issues one access at a time, inserts programmable RAM wait states, and produces the stall signal that freezes the pipeline while a CPU access is pending.

## Interface
- WAIT_CYCLES, default 0: extra RAM latency cycles per access (0–7).
- clock  in  1  system clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-low reset.
- cpu_req  in  1  MEM stage requests an access; held with cpu_we/cpu_addr/cpu_wdata stable until cpu_ack.
- cpu_we  in  1  1 = write, 0 = read.
- cpu_addr  in  16  word address.
- cpu_wdata  in  16  write data.
- cpu_rdata  out  16  read data register; valid from the cpu_ack cycle onward.
- cpu_ack  out  1  one-cycle completion pulse.
- cpu_stall  out  1  combinational: cpu_req & ~cpu_ack.
- host_req / host_we / host_addr[16] / host_wdata[16]  in  same meaning for the host port.
- host_rdata  out  16  host read data register.
- host_ack  out  1  one-cycle completion pulse.
- mem_addr  out  16  RAM address.
- mem_we  out  1  RAM write strobe.
- mem_wdata  out  16  RAM write data.
- mem_rdata  in  16  RAM read data; valid WAIT_CYCLES+1 cycles after the address is presented.
- grant_cpu  out  1  1 while a CPU access is in flight (status/debug).

## Operation
- States:
  - IDLE: no access in flight.
  - BUSY: one access in flight; a 3-bit down-counter `cnt` and an owner bit track it.
- IDLE arbitration: eligible requesters are those with req=1, excluding any requester whose ack is high in the current cycle.
  - Only one eligible: it wins.
  - Both eligible: round-robin; the winner is the requester not recorded in `last` (last-granted bit).
- On a grant:
  - latch addr/we/wdata into internal registers;
  - owner ← winner, last ← winner, cnt ← WAIT_CYCLES;
  - go to BUSY.
- BUSY outputs:
  - mem_addr and mem_wdata are driven from the latched registers.
  - mem_we = latched we, asserted only in the first BUSY cycle.
  - grant_cpu = (owner == CPU).
- BUSY, cnt ≠ 0: cnt decrements each cycle.
- BUSY, cnt == 0:
  - if read, capture mem_rdata into the owner's rdata register;
  - set the owner's ack for the next cycle;
  - go to IDLE.
- Writes never modify either rdata register.
- Dropping req mid-access does not abort: the access completes and ack still pulses.
- IDLE outputs: mem_we=0; mem_addr and mem_wdata hold their last values.

## Timing
- Reset values: state IDLE, cnt 0, last = HOST (so the CPU wins the first tie), cpu_ack 0, host_ack 0, mem_we 0, mem_addr 0, mem_wdata 0, cpu_rdata 0, host_rdata 0, grant_cpu 0.
- Reset is asynchronous. Asserting reset mid-BUSY abandons the access immediately:
  - mem_we drops at once;
  - no ack is produced after reset releases.
- Latency, with req first seen in IDLE in cycle 0:
  - BUSY in cycles 1 … 1+WAIT_CYCLES;
  - ack high in cycle 2+WAIT_CYCLES, and the arbiter is back in IDLE in that same cycle;
  - the other requester can be granted in that cycle.
- Per-requester throughput: at most one access per WAIT_CYCLES+3 cycles, because of the ack-cycle mask.
- With both requesters continuously active, grants strictly alternate.
- cpu_stall is combinational:
  - high from the first cycle of cpu_req through the cycle before cpu_ack;
  - low in the cpu_ack cycle, so the pipeline advances on that edge.
- A request arriving while BUSY waits in IDLE arbitration; no request is ever lost or reordered within a port.

## Test plan
- Single CPU read, WAIT_CYCLES=0, RAM[0x0010]=0xBEEF: cpu_req at cycle 0 → mem_addr=0x0010 in cycle 1; cpu_ack and cpu_rdata=0xBEEF in cycle 2; cpu_stall high in cycles 0–1 and low in cycle 2.
- CPU write, WAIT_CYCLES=3, addr 0x0020, data 0x1234: mem_we high in cycle 1 only; cpu_ack in cycle 5; RAM[0x0020]=0x1234; cpu_rdata unchanged.
- Simultaneous requests out of reset, host read 0x0001 and CPU read 0x0002: CPU is granted first (ack in cycle 2); host is granted next (ack in cycle 4); grant_cpu is 1 only in cycle 1.
- Both requesters held high for 20 cycles, WAIT_CYCLES=0: ack pulses alternate CPU, host, CPU, …, and no port receives two consecutive grants.
- Host read in flight with WAIT_CYCLES=5, then host_req dropped in cycle 2: host_ack still pulses in cycle 7 with correct host_rdata.
- reset asserted in cycle 2 of a CPU write with WAIT_CYCLES=4: all outputs go to reset values immediately; no ack ever appears; a new cpu_req after release completes normally with ack 2+WAIT_CYCLES cycles later.

Source files
------------

// File: rtl/dmem_arbiter.sv
// dmem_arbiter: shares the single-port 16-bit data RAM between the CPU MEM
// stage and the host/loader port. Issues one access at a time, stretches it
// by WAIT_CYCLES RAM wait states, round-robins on ties and stalls the CPU
// while its access is pending.
module dmem_arbiter #(
  parameter int unsigned WAIT_CYCLES = 0
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        cpu_req_i,
  input  logic        cpu_we_i,
  input  logic [15:0] cpu_addr_i,
  input  logic [15:0] cpu_wdata_i,
  output logic [15:0] cpu_rdata_o,
  output logic        cpu_ack_o,
  output logic        cpu_stall_c_o,
  input  logic        host_req_i,
  input  logic        host_we_i,
  input  logic [15:0] host_addr_i,
  input  logic [15:0] host_wdata_i,
  output logic [15:0] host_rdata_o,
  output logic        host_ack_o,
  output logic [15:0] mem_addr_o,
  output logic        mem_we_o,
  output logic [15:0] mem_wdata_o,
  input  logic [15:0] mem_rdata_i,
  output logic        grant_cpu_o
);

  localparam int unsigned AW = 16;
  localparam int unsigned DW = 16;
  localparam int unsigned CW = 3;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_e;

  // owner/last encoding: 1 = CPU, 0 = HOST
  state_e          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            owner_q, owner_d;
  logic            last_q, last_d;
  logic [AW-1:0]   addr_q, addr_d;
  logic [DW-1:0]   wdata_q, wdata_d;
  logic            we_q, we_d;
  logic            mem_we_q, mem_we_d;
  logic            grant_cpu_q, grant_cpu_d;
  logic            cpu_ack_q, cpu_ack_d;
  logic            host_ack_q, host_ack_d;
  logic [DW-1:0]   cpu_rdata_q, cpu_rdata_d;
  logic [DW-1:0]   host_rdata_q, host_rdata_d;
  logic            cpu_elig, host_elig, pick_cpu;

  // State and datapath registers; reset abandons any access in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      owner_q      <= 1'b0;
      last_q       <= 1'b0;
      addr_q       <= '0;
      wdata_q      <= '0;
      we_q         <= 1'b0;
      mem_we_q     <= 1'b0;
      grant_cpu_q  <= 1'b0;
      cpu_ack_q    <= 1'b0;
      host_ack_q   <= 1'b0;
      cpu_rdata_q  <= '0;
      host_rdata_q <= '0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      owner_q      <= owner_d;
      last_q       <= last_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      we_q         <= we_d;
      mem_we_q     <= mem_we_d;
      grant_cpu_q  <= grant_cpu_d;
      cpu_ack_q    <= cpu_ack_d;
      host_ack_q   <= host_ack_d;
      cpu_rdata_q  <= cpu_rdata_d;
      host_rdata_q <= host_rdata_d;
    end
  end

  // Arbitration, wait-state countdown and completion.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    owner_d      = owner_q;
    last_d       = last_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    we_d         = we_q;
    mem_we_d     = 1'b0;
    grant_cpu_d  = grant_cpu_q;
    cpu_ack_d    = 1'b0;
    host_ack_d   = 1'b0;
    cpu_rdata_d  = cpu_rdata_q;
    host_rdata_d = host_rdata_q;

    // A port acked this cycle is masked so its held request is not re-granted.
    cpu_elig  = cpu_req_i & ~cpu_ack_q;
    host_elig = host_req_i & ~host_ack_q;
    pick_cpu  = cpu_elig & (~host_elig | ~last_q);

    case (state_q)
      IDLE: begin
        if (cpu_elig || host_elig) begin
          state_d     = BUSY;
          owner_d     = pick_cpu;
          last_d      = pick_cpu;
          cnt_d       = CW'(WAIT_CYCLES);
          grant_cpu_d = pick_cpu;
          if (pick_cpu) begin
            addr_d   = cpu_addr_i;
            wdata_d  = cpu_wdata_i;
            we_d     = cpu_we_i;
            mem_we_d = cpu_we_i;
          end else begin
            addr_d   = host_addr_i;
            wdata_d  = host_wdata_i;
            we_d     = host_we_i;
            mem_we_d = host_we_i;
          end
        end
      end
      BUSY: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - CW'(1);
        end else begin
          if (!we_q) begin
            if (owner_q) cpu_rdata_d  = mem_rdata_i;
            else         host_rdata_d = mem_rdata_i;
          end
          cpu_ack_d   = owner_q;
          host_ack_d  = ~owner_q;
          grant_cpu_d = 1'b0;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign mem_addr_o    = addr_q;
  assign mem_wdata_o   = wdata_q;
  assign mem_we_o      = mem_we_q;
  assign grant_cpu_o   = grant_cpu_q;
  assign cpu_ack_o     = cpu_ack_q;
  assign host_ack_o    = host_ack_q;
  assign cpu_rdata_o   = cpu_rdata_q;
  assign host_rdata_o  = host_rdata_q;
  assign cpu_stall_c_o = cpu_req_i & ~cpu_ack_q;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter: four instances (WAIT_CYCLES 0,3,5,4)
// share one stimulus; each scenario checks the instance it targets.
module tb_dmem_arbiter;

  logic        clk;
  logic        rst_n;
  logic        cpu_req, cpu_we, host_req, host_we;
  logic [15:0] cpu_addr, cpu_wdata, host_addr, host_wdata;
  logic        pl_en;
  logic [7:0]  pl_addr;
  logic [15:0] pl_data;

  logic [3:0]       cpu_ack, host_ack, mem_we, grant_cpu, cpu_stall;
  logic [3:0][15:0] cpu_rdata, host_rdata, mem_addr, mem_wdata, mem_rdata, ram_20;

  int checks = 0;
  int errors = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  for (genvar g = 0; g < 4; g++) begin : gen_dut
    localparam int unsigned WC = (g == 0) ? 0 : (g == 1) ? 3 : (g == 2) ? 5 : 4;
    logic [15:0] ram [256];

    dmem_arbiter #(.WAIT_CYCLES(WC)) u_dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .cpu_req_i    (cpu_req),
      .cpu_we_i     (cpu_we),
      .cpu_addr_i   (cpu_addr),
      .cpu_wdata_i  (cpu_wdata),
      .cpu_rdata_o  (cpu_rdata[g]),
      .cpu_ack_o    (cpu_ack[g]),
      .cpu_stall_c_o(cpu_stall[g]),
      .host_req_i   (host_req),
      .host_we_i    (host_we),
      .host_addr_i  (host_addr),
      .host_wdata_i (host_wdata),
      .host_rdata_o (host_rdata[g]),
      .host_ack_o   (host_ack[g]),
      .mem_addr_o   (mem_addr[g]),
      .mem_we_o     (mem_we[g]),
      .mem_wdata_o  (mem_wdata[g]),
      .mem_rdata_i  (mem_rdata[g]),
      .grant_cpu_o  (grant_cpu[g])
    );

    // RAM model: read data stable for as long as the address is held.
    always @(posedge clk) begin
      if (pl_en) ram[pl_addr] <= pl_data;
      else if (mem_we[g]) ram[mem_addr[g][7:0]] <= mem_wdata[g];
    end
    assign mem_rdata[g] = ram[mem_addr[g][7:0]];
    assign ram_20[g]    = ram[8'h20];
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = '0; cpu_wdata = '0;
    host_req = 1'b0; host_we = 1'b0; host_addr = '0; host_wdata = '0;
  endtask

  task automatic apply_reset();
    rst_n = 1'b0;
    idle_inputs();
    repeat (2) cyc();
    rst_n = 1'b1;
  endtask

  task automatic preload();
    logic [7:0]  a [6];
    logic [15:0] d [6];
    a = '{8'h10, 8'h01, 8'h02, 8'h20, 8'h30, 8'h40};
    d = '{16'hBEEF, 16'h1111, 16'h2222, 16'h0000, 16'hCAFE, 16'h5A5A};
    for (int i = 0; i < 6; i++) begin
      pl_en = 1'b1; pl_addr = a[i]; pl_data = d[i];
      cyc();
    end
    pl_en = 1'b0;
  endtask

  task automatic test_reset();
    for (int i = 0; i < 4; i++) begin
      checks++;
      if ({cpu_ack[i], host_ack[i], mem_we[i], grant_cpu[i], mem_addr[i], mem_wdata[i],
           cpu_rdata[i], host_rdata[i]} !== 68'h0) begin
        errors++;
        $display("FAIL reset_outputs inst%0d: got ack=%b/%b we=%b gc=%b addr=%h wd=%h rd=%h/%h want all zero",
                 i, cpu_ack[i], host_ack[i], mem_we[i], grant_cpu[i], mem_addr[i], mem_wdata[i],
                 cpu_rdata[i], host_rdata[i]);
      end
    end
  endtask

  task automatic test_cpu_read();
    apply_reset();
    cyc();                                  // cycle 0
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 16'h0010;
    #1;
    checks++;
    if (cpu_stall[0] !== 1'b1) begin
      errors++; $display("FAIL rd_stall c0: got %b want 1", cpu_stall[0]);
    end
    cyc();                                  // cycle 1
    checks++;
    if (mem_addr[0] !== 16'h0010 || grant_cpu[0] !== 1'b1 || cpu_stall[0] !== 1'b1) begin
      errors++;
      $display("FAIL rd_c1: got addr=%h gc=%b stall=%b want addr=0010 gc=1 stall=1",
               mem_addr[0], grant_cpu[0], cpu_stall[0]);
    end
    cyc();                                  // cycle 2
    checks++;
    if (cpu_ack[0] !== 1'b1 || cpu_rdata[0] !== 16'hBEEF || cpu_stall[0] !== 1'b0) begin
      errors++;
      $display("FAIL rd_c2: got ack=%b rdata=%h stall=%b want ack=1 rdata=beef stall=0",
               cpu_ack[0], cpu_rdata[0], cpu_stall[0]);
    end
    cpu_req = 1'b0;
    cyc();                                  // cycle 3
    checks++;
    if (cpu_ack[0] !== 1'b0) begin
      errors++; $display("FAIL rd_ack_pulse c3: got %b want 0", cpu_ack[0]);
    end
  endtask

  task automatic test_cpu_write();
    apply_reset();
    cyc();
    cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 16'h0020; cpu_wdata = 16'h1234;
    for (int c = 1; c <= 6; c++) begin
      cyc();
      checks++;
      if (mem_we[1] !== (c == 1) || cpu_ack[1] !== (c == 5)) begin
        errors++;
        $display("FAIL wr_seq c%0d: got we=%b ack=%b want we=%b ack=%b",
                 c, mem_we[1], cpu_ack[1], (c == 1), (c == 5));
      end
      if (c == 5) cpu_req = 1'b0;
    end
    checks++;
    if (ram_20[1] !== 16'h1234) begin
      errors++; $display("FAIL wr_ram: got %h want 1234", ram_20[1]);
    end
    checks++;
    if (cpu_rdata[1] !== 16'h0000) begin
      errors++; $display("FAIL wr_rdata_kept: got %h want 0000", cpu_rdata[1]);
    end
  endtask

  task automatic test_simultaneous();
    apply_reset();
    cyc();
    cpu_req = 1'b1;  cpu_we = 1'b0;  cpu_addr = 16'h0002;
    host_req = 1'b1; host_we = 1'b0; host_addr = 16'h0001;
    for (int c = 1; c <= 5; c++) begin
      cyc();
      checks++;
      if (grant_cpu[0] !== (c == 1) || cpu_ack[0] !== (c == 2) || host_ack[0] !== (c == 4)) begin
        errors++;
        $display("FAIL sim_seq c%0d: got gc=%b cack=%b hack=%b want gc=%b cack=%b hack=%b",
                 c, grant_cpu[0], cpu_ack[0], host_ack[0], (c == 1), (c == 2), (c == 4));
      end
      if (c == 2) begin
        checks++;
        if (cpu_rdata[0] !== 16'h2222) begin
          errors++; $display("FAIL sim_cpu_rdata: got %h want 2222", cpu_rdata[0]);
        end
        cpu_req = 1'b0;
      end
      if (c == 4) begin
        checks++;
        if (host_rdata[0] !== 16'h1111) begin
          errors++; $display("FAIL sim_host_rdata: got %h want 1111", host_rdata[0]);
        end
        host_req = 1'b0;
      end
    end
  endtask

  task automatic test_back_to_back();
    apply_reset();
    cyc();
    cpu_req = 1'b1;  cpu_we = 1'b0;  cpu_addr = 16'h0002;
    host_req = 1'b1; host_we = 1'b0; host_addr = 16'h0001;
    for (int c = 1; c <= 20; c++) begin
      cyc();
      checks++;
      if (cpu_ack[0] !== (c % 4 == 2) || host_ack[0] !== (c % 4 == 0)) begin
        errors++;
        $display("FAIL b2b c%0d: got cack=%b hack=%b want cack=%b hack=%b",
                 c, cpu_ack[0], host_ack[0], (c % 4 == 2), (c % 4 == 0));
      end
    end
    idle_inputs();
  endtask

  task automatic test_host_drop();
    apply_reset();
    cyc();
    host_req = 1'b1; host_we = 1'b0; host_addr = 16'h0030;
    for (int c = 1; c <= 8; c++) begin
      cyc();
      if (c == 2) host_req = 1'b0;
      checks++;
      if (host_ack[2] !== (c == 7) || grant_cpu[2] !== 1'b0) begin
        errors++;
        $display("FAIL drop_seq c%0d: got hack=%b gc=%b want hack=%b gc=0",
                 c, host_ack[2], grant_cpu[2], (c == 7));
      end
    end
    checks++;
    if (host_rdata[2] !== 16'hCAFE) begin
      errors++; $display("FAIL drop_rdata: got %h want cafe", host_rdata[2]);
    end
  endtask

  task automatic test_reset_mid_busy();
    apply_reset();
    cyc();
    cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 16'h0040; cpu_wdata = 16'h7777;
    cyc();                                  // cycle 1
    checks++;
    if (mem_we[3] !== 1'b1 || grant_cpu[3] !== 1'b1) begin
      errors++; $display("FAIL rst_c1: got we=%b gc=%b want we=1 gc=1", mem_we[3], grant_cpu[3]);
    end
    cyc();                                  // cycle 2
    rst_n = 1'b0;
    cpu_req = 1'b0;
    #1;
    checks++;
    if ({cpu_ack[3], mem_we[3], grant_cpu[3], mem_addr[3], mem_wdata[3]} !== 35'h0) begin
      errors++;
      $display("FAIL rst_async: got ack=%b we=%b gc=%b addr=%h wd=%h want all zero",
               cpu_ack[3], mem_we[3], grant_cpu[3], mem_addr[3], mem_wdata[3]);
    end
    repeat (2) cyc();
    rst_n = 1'b1;
    for (int c = 0; c < 8; c++) begin
      cyc();
      checks++;
      if (cpu_ack[3] !== 1'b0) begin
        errors++; $display("FAIL rst_no_ack c%0d: got %b want 0", c, cpu_ack[3]);
      end
    end
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 16'h0010;
    for (int c = 1; c <= 7; c++) begin
      cyc();
      checks++;
      if (cpu_ack[3] !== (c == 6)) begin
        errors++; $display("FAIL rst_after c%0d: got ack=%b want %b", c, cpu_ack[3], (c == 6));
      end
      if (c == 6) begin
        checks++;
        if (cpu_rdata[3] !== 16'hBEEF) begin
          errors++; $display("FAIL rst_after_rdata: got %h want beef", cpu_rdata[3]);
        end
        cpu_req = 1'b0;
      end
    end
  endtask

  initial begin
    rst_n = 1'b0;
    pl_en = 1'b0; pl_addr = '0; pl_data = '0;
    idle_inputs();
    preload();
    test_reset();
    test_cpu_read();
    test_cpu_write();
    test_simultaneous();
    test_back_to_back();
    test_host_drop();
    test_reset_mid_busy();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
